lsu_ctrl: RTL and testbench

Load/store unit for the core's data-memory path. It takes one load or store per instruction from the execute stage and runs a request/grant/response transaction on the data-memory bus. It generates byte enables and replicated store data. It returns aligned, sign- or zero-extended load data to the write-back select's load-data input (`wb_sel = 2'b01`), and stalls the core while the access is outstanding.

---
 rtl/lsu_ctrl.sv | 98 +++++++++
 tb/tb_lsu_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit driving a req/gnt/rvalid data-memory bus; LSU_MISALIGN_TRAP_EN enables misalignment trapping.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3;
  logic [1:0]    off;
  logic          is_byte, is_half, is_word, trap, acc, timeout;
  logic [31:0]   addr_al, wd, ld_fmt;
  logic [3:0]    be;
  logic [7:0]    lb;
  logic [15:0]   lh;
  assign is_byte = i_funct3[1:0] == 2'b00;
  assign is_half = i_funct3[1:0] == 2'b01;
  assign is_word = !is_byte && !is_half;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap       = (is_half && i_addr[0]) || (is_word && |i_addr[1:0]);
  assign addr_al    = i_addr;
  assign o_misalign = !i_rst && state == IDLE && i_req && trap;
`else
  assign trap       = 1'b0;
  assign addr_al    = {i_addr[31:2], is_word ? 2'b00 : {i_addr[1], i_addr[0] & ~is_half}};
  assign o_misalign = 1'b0;
`endif
  assign acc     = state == IDLE && i_req && !trap;
  assign be      = is_byte ? 4'b0001 << addr_al[1:0] : is_half ? 4'b0011 << addr_al[1:0] : 4'b1111;
  assign wd      = is_byte ? {4{i_wdata[7:0]}} : is_half ? {2{i_wdata[15:0]}} : i_wdata;
  assign lb      = 8'(i_mem_rdata >> {off, 3'b000});
  assign lh      = 16'(i_mem_rdata >> {off[1], 4'b0000});
  // funct3[2] selects zero-extension for byte/half loads
  assign ld_fmt  = f3[1:0] == 2'b00 ? {{24{lb[7] & ~f3[2]}}, lb} :
                   f3[1:0] == 2'b01 ? {{16{lh[15] & ~f3[2]}}, lh} : i_mem_rdata;
  assign timeout    = state == WAIT && !i_mem_rvalid && cnt == CW'(TIMEOUT_CYC);
  assign o_bus_err  = !i_rst && timeout;
  assign o_ld_valid = !i_rst && state == DONE && !o_mem_we;
  assign o_stall    = acc || state == REQ || state == WAIT;
  assign o_mem_req  = state == REQ;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      f3          <= '0;
      off         <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_ld_data   <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          state       <= REQ;
          o_mem_we    <= i_we;
          o_mem_addr  <= {addr_al[31:2], 2'b00};
          o_mem_be    <= be;
          o_mem_wdata <= wd;
          f3          <= i_funct3;
          off         <= addr_al[1:0];
        end
        REQ: if (i_mem_gnt) begin
          state <= o_mem_we ? DONE : WAIT;
          cnt   <= '0;
        end
        WAIT: if (i_mem_rvalid || timeout) begin
          state     <= DONE;
          o_ld_data <= i_mem_rvalid ? ld_fmt : '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl with TIMEOUT_CYC=4.
module tb_lsu_ctrl;
  logic        i_clk = 1'b0, i_rst, i_req, i_we, i_mem_gnt, i_mem_rvalid;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic        o_stall, o_ld_valid, o_misalign, o_bus_err, o_mem_req, o_mem_we;
  logic [31:0] o_ld_data, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  int          checks = 0, errors = 0;
  logic [31:0] sb[$];

  always #5 i_clk = ~i_clk;

  lsu_ctrl #(.TIMEOUT_CYC(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_ld_data(o_ld_data),
    .o_ld_valid(o_ld_valid), .o_misalign(o_misalign), .o_bus_err(o_bus_err),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pop_chk();
    chk("ld_valid", 32'(o_ld_valid), 32'd1);
    if (o_ld_valid && sb.size() > 0) chk("ld_data", o_ld_data, sb.pop_front());
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp, input logic [3:0] exp_be, input int gd);
    i_req = 1; i_we = 0; i_funct3 = f3; i_addr = addr;
    sb.push_back(exp);
    @(negedge i_clk);
    chk("ld_c0_stall", 32'(o_stall), 32'd1);
    chk("ld_c0_misalign", 32'(o_misalign), 32'd0);
    nxt();
    repeat (gd) begin
      @(negedge i_clk);
      chk("ld_req_hold", 32'(o_mem_req), 32'd1);
      nxt();
    end
    i_mem_gnt = 1;
    @(negedge i_clk);
    chk("ld_mem_req", 32'(o_mem_req), 32'd1);
    chk("ld_mem_addr", o_mem_addr, {addr[31:2], 2'b00});
    chk("ld_mem_be", 32'(o_mem_be), 32'(exp_be));
    chk("ld_mem_we", 32'(o_mem_we), 32'd0);
    nxt();
    i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = rdata;
    @(negedge i_clk);
    chk("ld_wait_stall", 32'(o_stall), 32'd1);
    chk("ld_wait_valid", 32'(o_ld_valid), 32'd0);
    nxt();
    i_mem_rvalid = 0; i_req = 0;
    @(negedge i_clk);
    chk("ld_done_stall", 32'(o_stall), 32'd0);
    pop_chk();
    nxt();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input int gd);
    i_req = 1; i_we = 1; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(negedge i_clk);
    chk("st_c0_stall", 32'(o_stall), 32'd1);
    nxt();
    repeat (gd) begin
      @(negedge i_clk);
      chk("st_req", 32'(o_mem_req), 32'd1);
      chk("st_stall", 32'(o_stall), 32'd1);
      chk("st_we", 32'(o_mem_we), 32'd1);
      chk("st_be", 32'(o_mem_be), 32'(exp_be));
      chk("st_wdata", o_mem_wdata, exp_wd);
      chk("st_addr", o_mem_addr, {addr[31:2], 2'b00});
      nxt();
    end
    i_mem_gnt = 1;
    @(negedge i_clk);
    chk("st_gnt_req", 32'(o_mem_req), 32'd1);
    nxt();
    i_mem_gnt = 0; i_req = 0;
    @(negedge i_clk);
    chk("st_done_stall", 32'(o_stall), 32'd0);
    chk("st_done_valid", 32'(o_ld_valid), 32'd0);
    nxt();
    @(negedge i_clk);
    chk("st_idle_req", 32'(o_mem_req), 32'd0);
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1; i_req = 0; i_we = 0; i_funct3 = 0; i_addr = 0; i_wdata = 0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
    @(negedge i_clk);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_be", 32'(o_mem_be), 32'd0);
    chk("rst_ld_data", o_ld_data, 32'd0);
    chk("rst_ld_valid", 32'(o_ld_valid), 32'd0);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    nxt();

    do_load(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0);
    do_load(3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80, 4'b1000, 1);
    do_load(3'b100, 32'h103, 32'h80112233, 32'h00000080, 4'b1000, 0);
    do_load(3'b101, 32'h102, 32'h80112233, 32'h00008011, 4'b1100, 0);
    do_load(3'b001, 32'h102, 32'h80112233, 32'hFFFF8011, 4'b1100, 2);
    do_load(3'b100, 32'h100, 32'h80112233, 32'h00000033, 4'b0001, 0);
    do_load(3'b111, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 0);

    do_store(3'b000, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 3);
    do_store(3'b001, 32'h202, 32'h00001234, 4'b1100, 32'h12341234, 0);
    do_store(3'b010, 32'h204, 32'h87654321, 4'b1111, 32'h87654321, 1);

    // Timeout: no rvalid; error pulses on the fifth WAIT cycle (count == 4)
    i_req = 1; i_we = 0; i_funct3 = 3'b010; i_addr = 32'h300;
    sb.push_back(32'h0);
    nxt();
    i_mem_gnt = 1;
    nxt();
    i_mem_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("to_no_err", 32'(o_bus_err), 32'd0);
      chk("to_stall", 32'(o_stall), 32'd1);
      nxt();
    end
    @(negedge i_clk);
    chk("to_bus_err", 32'(o_bus_err), 32'd1);
    nxt();
    i_req = 0;
    @(negedge i_clk);
    chk("to_err_clear", 32'(o_bus_err), 32'd0);
    pop_chk();
    nxt();
    i_mem_rvalid = 1; i_mem_rdata = 32'hFFFFFFFF;
    @(negedge i_clk);
    chk("stray_valid", 32'(o_ld_valid), 32'd0);
    chk("stray_stall", 32'(o_stall), 32'd0);
    nxt();
    i_mem_rvalid = 0;
    @(negedge i_clk);
    chk("stray_ld_data", o_ld_data, 32'd0);
    nxt();

`ifdef LSU_MISALIGN_TRAP_EN
    i_req = 1; i_we = 0; i_funct3 = 3'b010; i_addr = 32'h102;
    @(negedge i_clk);
    chk("mis_flag", 32'(o_misalign), 32'd1);
    chk("mis_stall", 32'(o_stall), 32'd0);
    nxt();
    i_req = 0;
    @(negedge i_clk);
    chk("mis_mem_req", 32'(o_mem_req), 32'd0);
    chk("mis_valid", 32'(o_ld_valid), 32'd0);
    chk("mis_flag_off", 32'(o_misalign), 32'd0);
    nxt();
    do_load(3'b010, 32'h108, 32'h12345678, 32'h12345678, 4'b1111, 0);
`else
    do_load(3'b010, 32'h102, 32'h12345678, 32'h12345678, 4'b1111, 0);
    do_load(3'b101, 32'h103, 32'h80112233, 32'h00008011, 4'b1100, 0);
`endif

    // Reset while waiting for a response, then a late rvalid
    i_req = 1; i_we = 0; i_funct3 = 3'b010; i_addr = 32'h400;
    nxt();
    i_mem_gnt = 1;
    nxt();
    i_mem_gnt = 0; i_rst = 1;
    nxt();
    i_rst = 0; i_req = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hAAAAAAAA;
    @(negedge i_clk);
    chk("wrst_stall", 32'(o_stall), 32'd0);
    chk("wrst_mem_req", 32'(o_mem_req), 32'd0);
    chk("wrst_mem_addr", o_mem_addr, 32'd0);
    chk("wrst_mem_be", 32'(o_mem_be), 32'd0);
    chk("wrst_mem_wdata", o_mem_wdata, 32'd0);
    chk("wrst_ld_data", o_ld_data, 32'd0);
    chk("wrst_ld_valid", 32'(o_ld_valid), 32'd0);
    nxt();
    i_mem_rvalid = 0;
    @(negedge i_clk);
    chk("wrst_late_valid", 32'(o_ld_valid), 32'd0);
    chk("wrst_late_data", o_ld_data, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
